// File: rtl/sonic_pkg.sv
// Shared types and constants for the sonic_ranger ultrasonic range finder.
package sonic_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_BLANK = 4'd12;

   typedef enum logic [1:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE
   } state_t;

endpackage

// File: rtl/sonic_ranger_if.sv
// Sensor and result signals of sonic_ranger; master is the ranger, slave is the sensor/consumer side.
interface sonic_ranger_if;
   import sonic_pkg::*;

   logic             echo;
   logic             trigger;
   logic [9:0]       dist_cm;
   logic [BCD_W-1:0] num0;
   logic [BCD_W-1:0] num1;
   logic [BCD_W-1:0] num2;
   logic             near;
   logic             timeout;
   logic             valid;

   modport master (
      input  echo,
      output trigger, dist_cm, num0, num1, num2, near, timeout, valid
   );

   modport slave (
      output echo,
      input  trigger, dist_cm, num0, num1, num2, near, timeout, valid
   );

endinterface

// File: rtl/sonic_bcd_cnt.sv
// Three-digit BCD incrementer with synchronous clear; holds at 999 and flags saturation.
module sonic_bcd_cnt
   import sonic_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [BCD_W-1:0] d0_o,
   output logic [BCD_W-1:0] d1_o,
   output logic [BCD_W-1:0] d2_o,
   output logic             sat_o
);

   logic [BCD_W-1:0] d0_q, d1_q, d2_q;
   logic [BCD_W-1:0] d0_d, d1_d, d2_d;

   assign sat_o = (d2_q == 4'd9) && (d1_q == 4'd9) && (d0_q == 4'd9);

   always_comb begin
      d0_d = d0_q;
      d1_d = d1_q;
      d2_d = d2_q;
      if (clr_i) begin
         d0_d = '0;
         d1_d = '0;
         d2_d = '0;
      end else if (inc_i && !sat_o) begin
         if (d0_q == 4'd9) begin
            d0_d = '0;
            if (d1_q == 4'd9) begin
               d1_d = '0;
               d2_d = d2_q + 1'b1;
            end else begin
               d1_d = d1_q + 1'b1;
            end
         end else begin
            d0_d = d0_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d0_q <= '0;
         d1_q <= '0;
         d2_q <= '0;
      end else begin
         d0_q <= d0_d;
         d1_q <= d1_d;
         d2_q <= d2_d;
      end
   end

   assign d0_o = d0_q;
   assign d1_o = d1_q;
   assign d2_o = d2_q;

endmodule

// File: rtl/sonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing to cm/BCD without a divider.
// Define SONIC_HYST_EN to give the near flag release hysteresis of HYST_CM.
module sonic_ranger
   import sonic_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int TRIG_CYCLES    = 500,
   parameter int PERIOD_CYCLES  = 3_000_000,
   parameter int TIMEOUT_CYCLES = 1_500_000,
   parameter int CYCLES_PER_CM  = 2900,
   parameter int MAX_CM         = 400,
   parameter int NEAR_CM        = 40,
   parameter int HYST_CM        = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   sonic_ranger_if.master bus
);

   localparam int FRAME_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam int CNT_MAX = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PRE_W   = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
   localparam int DIST_W  = 10;

   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TRIG_LAST  = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CYCLES_PER_CM - 1);
   localparam logic [DIST_W-1:0]  MAX_LIM    = DIST_W'(MAX_CM);
   localparam logic [DIST_W-1:0]  NEAR_LIM   = DIST_W'(NEAR_CM);
`ifdef SONIC_HYST_EN
   localparam logic [DIST_W-1:0]  REL_LIM    = DIST_W'(NEAR_CM + HYST_CM);
`endif

   if (CLK_HZ < 1 || HYST_CM < 0 || CYCLES_PER_CM < 2) begin : g_cfg_chk
      $error("sonic_ranger: invalid parameter set");
   end

   state_t              state_q, state_d;
   logic [FRAME_W-1:0]  frame_q, frame_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [DIST_W-1:0]   dist_q, dist_d;
   logic [DIST_W-1:0]   dist_cm_q, dist_cm_d;
   logic [BCD_W-1:0]    num0_q, num0_d, num1_q, num1_d, num2_q, num2_d;
   logic                near_q, near_d, timeout_q, timeout_d, valid_q, valid_d;
   logic                echo_meta_q, echo_s_q, echo_prev_q;
   logic                rise, fall, count_en, res_timeout, res_latch;
   logic                bcd_clr, bcd_inc, bcd_sat;
   logic [BCD_W-1:0]    bcd0, bcd1, bcd2;

   // Echo is asynchronous: two-flop synchroniser plus one flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         echo_meta_q <= 1'b0;
         echo_s_q    <= 1'b0;
         echo_prev_q <= 1'b0;
      end else begin
         echo_meta_q <= bus.echo;
         echo_s_q    <= echo_meta_q;
         echo_prev_q <= echo_s_q;
      end
   end

   assign rise = echo_s_q & ~echo_prev_q;
   assign fall = ~echo_s_q & echo_prev_q;

   sonic_bcd_cnt u_bcd (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (bcd_clr),
      .inc_i (bcd_inc),
      .d0_o  (bcd0),
      .d1_o  (bcd1),
      .d2_o  (bcd2),
      .sat_o (bcd_sat)
   );

   always_comb begin
      state_d     = state_q;
      frame_d     = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
      cnt_d       = cnt_q;
      pre_d       = pre_q;
      dist_d      = dist_q;
      dist_cm_d   = dist_cm_q;
      num0_d      = num0_q;
      num1_d      = num1_q;
      num2_d      = num2_q;
      near_d      = near_q;
      timeout_d   = timeout_q;
      valid_d     = 1'b0;
      bcd_clr     = 1'b0;
      bcd_inc     = 1'b0;
      count_en    = 1'b0;
      res_timeout = 1'b0;
      res_latch   = 1'b0;

      // Frame wrap outside IDLE aborts the measurement and restarts the trigger at once
      if (state_q != IDLE && frame_q == '0) begin
         res_timeout = 1'b1;
         state_d     = TRIG;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_q == '0) state_d = TRIG;
            end
            TRIG: begin
               if (cnt_q == TRIG_LAST) begin
                  state_d = WAIT_RISE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            WAIT_RISE: begin
               if (rise) begin
                  state_d  = MEASURE;
                  cnt_d    = CNT_W'(1);
                  count_en = 1'b1;
               end else if (cnt_q == TMO_LAST) begin
                  res_timeout = 1'b1;
                  state_d     = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            MEASURE: begin
               if (fall) begin
                  res_latch = 1'b1;
                  state_d   = IDLE;
               end else if (cnt_q == TMO_LAST) begin
                  res_timeout = 1'b1;
                  state_d     = IDLE;
               end else begin
                  cnt_d    = cnt_q + 1'b1;
                  count_en = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // The rising-echo cycle is counted too, so the counted width equals the echo width
      if (count_en) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (!bcd_sat) begin
               bcd_inc = 1'b1;
               dist_d  = dist_q + 1'b1;
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end

      if (state_d == TRIG && state_q != TRIG) begin
         cnt_d   = '0;
         pre_d   = '0;
         dist_d  = '0;
         bcd_clr = 1'b1;
      end

      if (res_timeout) begin
         valid_d   = 1'b1;
         timeout_d = 1'b1;
         near_d    = 1'b0;
         num0_d    = BCD_BLANK;
         num1_d    = BCD_BLANK;
         num2_d    = BCD_BLANK;
      end else if (res_latch) begin
         valid_d   = 1'b1;
         timeout_d = 1'b0;
         dist_cm_d = dist_q;
         if (dist_q > MAX_LIM) begin
            near_d = 1'b0;
            num0_d = BCD_BLANK;
            num1_d = BCD_BLANK;
            num2_d = BCD_BLANK;
         end else begin
            num0_d = bcd0;
            num1_d = bcd1;
            num2_d = bcd2;
`ifdef SONIC_HYST_EN
            if (dist_q < NEAR_LIM) near_d = 1'b1;
            else if (dist_q >= REL_LIM) near_d = 1'b0;
`else
            near_d = (dist_q < NEAR_LIM);
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         cnt_q     <= '0;
         pre_q     <= '0;
         dist_q    <= '0;
         dist_cm_q <= '0;
         num0_q    <= BCD_BLANK;
         num1_q    <= BCD_BLANK;
         num2_q    <= BCD_BLANK;
         near_q    <= 1'b0;
         timeout_q <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         cnt_q     <= cnt_d;
         pre_q     <= pre_d;
         dist_q    <= dist_d;
         dist_cm_q <= dist_cm_d;
         num0_q    <= num0_d;
         num1_q    <= num1_d;
         num2_q    <= num2_d;
         near_q    <= near_d;
         timeout_q <= timeout_d;
         valid_q   <= valid_d;
      end
   end

   assign bus.trigger = (state_q == TRIG);
   assign bus.dist_cm = dist_cm_q;
   assign bus.num0    = num0_q;
   assign bus.num1    = num1_q;
   assign bus.num2    = num2_q;
   assign bus.near    = near_q;
   assign bus.timeout = timeout_q;
   assign bus.valid   = valid_q;

endmodule

// File: tb/tb_sonic_ranger.sv
// Directed bench for sonic_ranger with small frame parameters; honours SONIC_HYST_EN.
module tb_sonic_ranger;
   import sonic_pkg::*;

`ifdef SONIC_HYST_EN
   localparam int HYST_ON = 1;
`else
   localparam int HYST_ON = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   sonic_ranger_if bus ();

   sonic_ranger #(
      .CLK_HZ         (100_000_000),
      .TRIG_CYCLES    (5),
      .PERIOD_CYCLES  (2000),
      .TIMEOUT_CYCLES (1500),
      .CYCLES_PER_CM  (10),
      .MAX_CM         (100),
      .NEAR_CM        (40),
      .HYST_CM        (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_trig(input logic lvl, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.trigger === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(input int bound, output int cyc, output bit ok);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 1; i <= bound; i++) begin
         @(negedge clk);
         if (bus.valid === 1'b1) begin
            ok  = 1'b1;
            cyc = i;
            break;
         end
      end
   endtask

   task automatic check_blank(input string tag);
      check({tag, "_num2"}, 32'(bus.num2), 32'd12);
      check({tag, "_num1"}, 32'(bus.num1), 32'd12);
      check({tag, "_num0"}, 32'(bus.num0), 32'd12);
   endtask

   task automatic meas(input string tag, input bit new_frame, input int width, input int ed,
                       input int e2, input int e1, input int e0, input int en);
      bit ok;
      int cyc;
      if (new_frame) begin
         wait_trig(1'b1, 4000, ok);
         check({tag, "_trig_rise"}, 32'(ok), 32'd1);
         wait_trig(1'b0, 20, ok);
         check({tag, "_trig_fall"}, 32'(ok), 32'd1);
      end
      repeat (10) @(negedge clk);
      bus.echo = 1'b1;
      repeat (width) @(negedge clk);
      bus.echo = 1'b0;
      wait_valid(50, cyc, ok);
      check({tag, "_valid_seen"}, 32'(ok), 32'd1);
      check({tag, "_dist"}, 32'(bus.dist_cm), 32'(ed));
      check({tag, "_num2"}, 32'(bus.num2), 32'(e2));
      check({tag, "_num1"}, 32'(bus.num1), 32'(e1));
      check({tag, "_num0"}, 32'(bus.num0), 32'(e0));
      check({tag, "_near"}, 32'(bus.near), 32'(en));
      check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
      @(negedge clk);
      check({tag, "_valid_strobe"}, 32'(bus.valid), 32'd0);
   endtask

   initial begin
      bit ok;
      int cyc;
      int hi;

      bus.echo = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_trigger", 32'(bus.trigger), 32'd0);
      check("rst_dist", 32'(bus.dist_cm), 32'd0);
      check_blank("rst");
      check("rst_near", 32'(bus.near), 32'd0);
      check("rst_timeout", 32'(bus.timeout), 32'd0);
      check("rst_valid", 32'(bus.valid), 32'd0);

      // Trigger rises on the first edge after release and lasts 5 clocks
      rst_n = 1'b1;
      @(negedge clk);
      check("trig_first", 32'(bus.trigger), 32'd1);
      hi = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.trigger === 1'b1) hi++;
         else break;
      end
      check("trig_len", 32'(hi), 32'd5);
      check("pre_echo_valid", 32'(bus.valid), 32'd0);
      check_blank("pre_echo");

      meas("e250", 1'b0, 250, 25, 0, 2, 5, 1);
      meas("e439", 1'b1, 439, 43, 0, 4, 3, HYST_ON);
      meas("e449", 1'b1, 449, 44, 0, 4, 4, HYST_ON);
      meas("e450", 1'b1, 450, 45, 0, 4, 5, 0);
      meas("e399", 1'b1, 399, 39, 0, 3, 9, 1);
      meas("e400", 1'b1, 400, 40, 0, 4, 0, HYST_ON);
      meas("e1009", 1'b1, 1009, 100, 1, 0, 0, 0);
      meas("e1010", 1'b1, 1010, 101, 12, 12, 12, 0);

      // No echo: timeout strobe exactly 1500 clocks after trigger fall
      wait_trig(1'b1, 4000, ok);
      check("noecho_trig_rise", 32'(ok), 32'd1);
      wait_trig(1'b0, 20, ok);
      wait_valid(2000, cyc, ok);
      check("noecho_valid_seen", 32'(ok), 32'd1);
      check("noecho_latency", 32'(cyc), 32'd1500);
      check("noecho_timeout", 32'(bus.timeout), 32'd1);
      check("noecho_dist_hold", 32'(bus.dist_cm), 32'd101);
      check("noecho_near", 32'(bus.near), 32'd0);
      check_blank("noecho");

      // Echo stuck high: width timeout, then the next frame still triggers
      wait_trig(1'b1, 4000, ok);
      wait_trig(1'b0, 20, ok);
      repeat (10) @(negedge clk);
      bus.echo = 1'b1;
      wait_valid(2000, cyc, ok);
      check("held_valid_seen", 32'(ok), 32'd1);
      check("held_timeout", 32'(bus.timeout), 32'd1);
      check("held_dist_hold", 32'(bus.dist_cm), 32'd101);
      check_blank("held");
      bus.echo = 1'b0;
      wait_trig(1'b1, 1000, ok);
      check("held_next_trig", 32'(ok), 32'd1);

      // Late echo still in MEASURE at frame wrap: abort coincides with new trigger
      wait_trig(1'b0, 20, ok);
      repeat (1300) @(negedge clk);
      bus.echo = 1'b1;
      wait_valid(1000, cyc, ok);
      check("wrap_valid_seen", 32'(ok), 32'd1);
      check("wrap_timeout", 32'(bus.timeout), 32'd1);
      check("wrap_trigger", 32'(bus.trigger), 32'd1);
      check_blank("wrap");
      bus.echo = 1'b0;
      wait_valid(2000, cyc, ok);
      check("wrap_next_timeout_seen", 32'(ok), 32'd1);
      check("wrap_next_timeout", 32'(bus.timeout), 32'd1);

      // Reset during MEASURE
      wait_trig(1'b1, 4000, ok);
      wait_trig(1'b0, 20, ok);
      repeat (10) @(negedge clk);
      bus.echo = 1'b1;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_trigger", 32'(bus.trigger), 32'd0);
      check("mid_rst_dist", 32'(bus.dist_cm), 32'd0);
      check_blank("mid_rst");
      check("mid_rst_near", 32'(bus.near), 32'd0);
      check("mid_rst_timeout", 32'(bus.timeout), 32'd0);
      check("mid_rst_valid", 32'(bus.valid), 32'd0);
      bus.echo = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_trig", 32'(bus.trigger), 32'd1);
      wait_trig(1'b0, 20, ok);
      check("post_rst_trig_fall", 32'(ok), 32'd1);
      meas("e120", 1'b0, 120, 12, 0, 1, 2, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sonic_ranger.md
# sonic_ranger

Parametrised ultrasonic range finder for HC-SR04-class sensors. Issues periodic trigger pulses and times the echo pulse. Converts echo width directly to centimetres and BCD digits using prescaled counters, with no divider. Flags near objects, echo timeouts and out-of-range readings. Feeds the seven-segment display path and any proximity logic.

## Interface
- CLK_HZ, 50_000_000: system clock frequency; documentation only, not used in logic.
- TRIG_CYCLES, 500: trigger high time in clocks (10 µs).
- PERIOD_CYCLES, 3_000_000: measurement frame length in clocks (60 ms).
- TIMEOUT_CYCLES, 1_500_000: maximum wait for echo rise, and maximum echo width.
- CYCLES_PER_CM, 2900: round-trip clocks per centimetre.
- MAX_CM, 400: readings above this are out of range.
- NEAR_CM, 40: near threshold.
- HYST_CM, 5: near release hysteresis; used only with SONIC_HYST_EN.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- echo  in  1  sensor echo, asynchronous to clk.
- trigger  out  1  sensor trigger.
- dist_cm  out  10  last distance in cm, saturating at 999.
- num0, num1, num2  out  4 each  BCD ones, tens and hundreds; 4'd12 on all three means no reading.
- near  out  1  object closer than threshold.
- timeout  out  1  last frame produced no valid echo.
- valid  out  1  one-cycle strobe when outputs update.

## Operation
- echo passes through a 2-flop synchroniser, giving echo_s; rise and fall are edge-detected on echo_s.
- Frame counter runs free over 0..PERIOD_CYCLES-1.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE.
- IDLE → TRIG when the frame counter is 0. Clear the cm and BCD counters and the prescaler.
- TRIG: hold trigger=1 for exactly TRIG_CYCLES clocks, then go to WAIT_RISE.
- WAIT_RISE:
  - echo_s rise → MEASURE.
  - TIMEOUT_CYCLES elapsed without a rise → timeout result, then IDLE.
- MEASURE: prescaler counts clocks while echo_s=1. On reaching CYCLES_PER_CM-1 it wraps and increments dist and the BCD chain.
  - The BCD chain saturates at 999.
  - Result is floor(width/CYCLES_PER_CM).
- MEASURE, echo_s fall → latch result, then IDLE.
- MEASURE, width reaches TIMEOUT_CYCLES → timeout result, then IDLE.
- Latched result when dist ≤ MAX_CM: dist_cm=dist, num2..num0=BCD, timeout=0.
- Latched result when dist > MAX_CM: dist_cm=dist, digits=4'd12, timeout=0, near=0.
- Timeout result: dist_cm unchanged, digits=4'd12, timeout=1, near=0.
- Frame wrap while not in IDLE aborts the measurement with a timeout result and starts the new TRIG in the same cycle.
- Echo edges in IDLE or TRIG are ignored.

## Timing
- Reset values: trigger=0, dist_cm=0, num0=num1=num2=4'd12, near=0, timeout=0, valid=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame forces trigger low immediately.
- After reset release, the first trigger rises on the first clk edge, since the frame counter is 0.
- Synchroniser latency is 2 clocks. Both echo edges are delayed equally, so counted width equals the true echo width.
- valid pulses for 1 cycle, coincident with the output update. This is 1 clock after echo_s fall is sampled, or on the timeout cycle.
- At most one valid pulse per frame.
- Outputs hold between valid pulses.

## Configuration
- SONIC_HYST_EN defined:
  - near sets when a valid in-range dist < NEAR_CM.
  - near clears when dist ≥ NEAR_CM+HYST_CM, or on out-of-range or timeout.
  - Otherwise near holds.
- SONIC_HYST_EN undefined: near = (dist < NEAR_CM) on each in-range valid, and 0 otherwise. HYST_CM is unused.

## Structure
- Package sonic_pkg holds the FSM state typedef, the BCD blank code constant (4'd12), and the BCD digit width.
- Sub-module sonic_bcd_cnt: 3-digit saturating BCD incrementer with clear, inc and saturation flag.
- The synchroniser, FSM, prescaler and frame counter live in sonic_ranger.

## Test plan
Bench parameters: TRIG=5, PERIOD=2000, TIMEOUT=1500, CYCLES_PER_CM=10, MAX_CM=100, NEAR=40, HYST=5.
- Reset release → trigger high exactly 5 cycles. Outputs show digits C/C/C, near=0, valid=0 until the first echo.
- Echo high 250 cycles → valid once; dist_cm=25, num1=2, num0=5, num2=0, near=1, timeout=0.
- Echo high 439 cycles, then 449, then 450, with hysteresis enabled:
  - 43 cm → near=1 (held).
  - 44 cm → near=1 (held).
  - 45 cm → near=0.
- Same sequence with hysteresis disabled → near=0 for 43, 44 and 45 cm.
- Echo high 1010 cycles → dist_cm=101, digits C/C/C, near=0, timeout=0.
- No echo in a frame → valid 1500 cycles after trigger fall, with timeout=1 and digits C/C/C.
- Echo held high through the frame → timeout result, then a new trigger at frame wrap.
- Reset asserted mid-MEASURE → trigger=0 and outputs at reset values immediately; normal frame follows after release.
